// File: rtl/channel_accumulator_pkg.sv
// Shared elaboration-time helpers for the channel accumulator and its quantiser.
package channel_accumulator_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++)
            if ((1 << r) < value) r++;
        return r;
    endfunction

    // Accumulator must hold NUM_ITER full-scale sums plus the bias without wrapping.
    function automatic bit acc_width_ok(input int acc_w, input int data_w, input int num_iter);
        return acc_w >= data_w + clog2(num_iter) + 1;
    endfunction

endpackage

// File: rtl/round_saturate.sv
// Rounding (half toward +inf) arithmetic right shift followed by signed saturation.
module round_saturate #(
    parameter int IN_WIDTH  = 40,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 4
) (
    input  logic [IN_WIDTH-1:0]  i_f,
    output logic [OUT_WIDTH-1:0] o_r
);

    logic signed [IN_WIDTH-1:0]    w_r;
    logic [IN_WIDTH-OUT_WIDTH:0]   w_hi;

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic [IN_WIDTH-1:0] HALF = IN_WIDTH'(1) << (SHIFT - 1);
            assign w_r = $signed(i_f + HALF) >>> SHIFT;
        end else begin : g_pass
            assign w_r = $signed(i_f);
        end
    endgenerate

    // In range only when every bit above the output sign bit matches it.
    assign w_hi = w_r[IN_WIDTH-1:OUT_WIDTH-1];

    always_comb begin
        o_r = w_r[OUT_WIDTH-1:0];
        if (!(&w_hi) && (|w_hi))
            o_r = w_r[IN_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                  : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end

endmodule

// File: rtl/channel_accumulator.sv
// Accumulates NUM_ITER adder-tree sums on top of a bias, then rounds, saturates
// and presents one quantised result per group on a valid/ready interface.
module channel_accumulator
    import channel_accumulator_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 40,
    parameter int OUT_WIDTH  = 16,
    parameter int NUM_ITER   = 4,
    parameter int SHIFT      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_bias,
    input  logic                  i_clear,
    output logic [OUT_WIDTH-1:0]  o_data,
    output logic                  o_valid,
    input  logic                  i_ready
);

    localparam int CNT_W = (NUM_ITER > 1) ? clog2(NUM_ITER) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_ITER - 1);

    generate
        if (!acc_width_ok(ACC_WIDTH, DATA_WIDTH, NUM_ITER) || NUM_ITER < 1 || SHIFT < 0) begin : g_param_err
            $error("channel_accumulator: illegal ACC_WIDTH/NUM_ITER/SHIFT combination");
        end
    endgenerate

    logic [CNT_W-1:0]            r_cnt;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic [OUT_WIDTH-1:0]        r_data;
    logic                        r_valid;

    logic                        w_ready;
    logic                        w_beat;
    logic                        w_first;
    logic                        w_last;
    logic signed [ACC_WIDTH-1:0] w_base;
    logic signed [ACC_WIDTH-1:0] w_f;
    logic [OUT_WIDTH-1:0]        w_res;

    assign w_ready = !r_valid || i_ready;
    assign w_beat  = i_valid && w_ready && !i_clear;
    assign w_first = (r_cnt == '0);
    assign w_last  = (r_cnt == LAST);

    // The final sum is formed combinationally so the result registers one cycle after the last beat.
    assign w_base = w_first ? ACC_WIDTH'($signed(i_bias)) : r_acc;
    assign w_f    = w_base + ACC_WIDTH'($signed(i_data));

    round_saturate #(
        .IN_WIDTH  (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .SHIFT     (SHIFT)
    ) u_round_saturate (
        .i_f (w_f),
        .o_r (w_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (w_beat) begin
            r_acc <= w_f;
            r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_beat && w_last) begin
            r_valid <= 1'b1;
            r_data  <= w_res;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_ready = w_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: tb/tb_channel_accumulator.sv
// Scoreboard bench: two instances (NUM_ITER=4/SHIFT=4 and NUM_ITER=1/SHIFT=0)
// checked against a group-sum reference model.
module tb_channel_accumulator;

    localparam int DW = 32;
    localparam int OW = 16;
    localparam int NI_A = 4, SH_A = 4;
    localparam int NI_B = 1, SH_B = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [DW-1:0] a_data = '0, a_bias = '0, b_data = '0, b_bias = '0;
    logic a_valid = 1'b0, a_clear = 1'b0, a_ready = 1'b1;
    logic b_valid = 1'b0, b_clear = 1'b0, b_ready = 1'b1;
    logic a_oready, a_ovalid, b_oready, b_ovalid;
    logic [OW-1:0] a_odata, b_odata;

    int n_vec = 0, n_bad = 0;
    bit rand_bp = 1'b0;
    longint qa[$], qb[$];
    longint ga_sum = 0, gb_sum = 0;
    int ga_n = 0, gb_n = 0;
    bit a_stall = 0, b_stall = 0;
    logic [OW-1:0] a_prev = '0, b_prev = '0;
    int b_run = 0;

    channel_accumulator #(.DATA_WIDTH(DW), .ACC_WIDTH(40), .OUT_WIDTH(OW), .NUM_ITER(NI_A), .SHIFT(SH_A)) u_a (
        .clk(clk), .rst(rst), .i_data(a_data), .i_valid(a_valid), .o_ready(a_oready), .i_bias(a_bias),
        .i_clear(a_clear), .o_data(a_odata), .o_valid(a_ovalid), .i_ready(a_ready));

    channel_accumulator #(.DATA_WIDTH(DW), .ACC_WIDTH(40), .OUT_WIDTH(OW), .NUM_ITER(NI_B), .SHIFT(SH_B)) u_b (
        .clk(clk), .rst(rst), .i_data(b_data), .i_valid(b_valid), .o_ready(b_oready), .i_bias(b_bias),
        .i_clear(b_clear), .o_data(b_odata), .o_valid(b_ovalid), .i_ready(b_ready));

    // Reference quantiser: floor((s + half) / 2^sh), then clamp to the output range.
    function automatic longint quant(input longint s, input int sh);
        longint r, hi, lo;
        r = s;
        if (sh > 0) r = (s + (longint'(1) << (sh - 1))) >>> sh;
        hi = (longint'(1) << (OW - 1)) - 1;
        lo = -(longint'(1) << (OW - 1));
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        return r;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            qa.delete(); ga_n = 0; ga_sum = 0; a_stall = 0;
        end else begin
            check("a_ready_rule", a_oready, !a_ovalid || a_ready);
            if (a_stall) begin
                check("a_hold_valid", a_ovalid, 1);
                check("a_hold_data", a_odata, a_prev);
            end
            if (a_ovalid && a_ready) begin
                if (qa.size() == 0) check("a_unexpected_valid", a_ovalid, 0);
                else check("a_result", longint'($signed(a_odata)), qa.pop_front());
            end
            a_stall = a_ovalid && !a_ready;
            a_prev  = a_odata;
            if (a_clear) begin
                ga_n = 0; ga_sum = 0;
            end else if (a_valid && a_oready) begin
                if (ga_n == 0) ga_sum = longint'($signed(a_bias));
                ga_sum += longint'($signed(a_data));
                ga_n++;
                if (ga_n == NI_A) begin qa.push_back(quant(ga_sum, SH_A)); ga_n = 0; end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            qb.delete(); gb_n = 0; gb_sum = 0; b_stall = 0; b_run = 0;
        end else begin
            b_run = b_ovalid ? b_run + 1 : 0;
            check("b_ready_rule", b_oready, !b_ovalid || b_ready);
            if (b_stall) begin
                check("b_hold_valid", b_ovalid, 1);
                check("b_hold_data", b_odata, b_prev);
            end
            if (b_ovalid && b_ready) begin
                if (qb.size() == 0) check("b_unexpected_valid", b_ovalid, 0);
                else check("b_result", longint'($signed(b_odata)), qb.pop_front());
            end
            b_stall = b_ovalid && !b_ready;
            b_prev  = b_odata;
            if (b_clear) begin
                gb_n = 0; gb_sum = 0;
            end else if (b_valid && b_oready) begin
                if (gb_n == 0) gb_sum = longint'($signed(b_bias));
                gb_sum += longint'($signed(b_data));
                gb_n++;
                if (gb_n == NI_B) begin qb.push_back(quant(gb_sum, SH_B)); gb_n = 0; end
            end
        end
    end

    // Present one beat and hold it until the DUT accepts it (bounded wait).
    task automatic send(input bit sel, input logic [DW-1:0] d, input logic [DW-1:0] b);
        int n;
        n = 0;
        if (sel) begin b_data = d; b_bias = b; b_valid = 1'b1; end
        else     begin a_data = d; a_bias = b; a_valid = 1'b1; end
        forever begin
            if (rand_bp) begin
                if (sel) b_ready = ($urandom_range(0, 3) != 0);
                else     a_ready = ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
            if (sel ? b_oready : a_oready) break;
            n++;
            if (n > 50) begin
                check(sel ? "b_send_timeout" : "a_send_timeout", sel ? b_oready : a_oready, 1);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        if (sel) b_valid = 1'b0; else a_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        a_ready = 1'b1; b_ready = 1'b1;
        while ((qa.size() != 0 || qb.size() != 0) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("drain_a", qa.size(), 0);
        check("drain_b", qb.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd_val(input bit big);
        logic [DW-1:0] v;
        if (big) v = $urandom();
        else v = DW'($signed($urandom_range(0, 4000)) - 2000);
        return v;
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_a_valid", a_ovalid, 0);
        check("reset_a_data", a_odata, 0);
        check("reset_b_valid", b_ovalid, 0);
        check("reset_b_data", b_odata, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // basic accumulate, single pulse one cycle after the last beat
        send(0, 16, 8); send(0, 32, 8); send(0, 48, 8); send(0, 64, 8);
        check("basic_latency", a_ovalid, 1);
        check("basic_value", longint'($signed(a_odata)), 11);
        @(posedge clk); #1;
        check("basic_single_pulse", a_ovalid, 0);

        // rounding of negatives
        send(0, -8, 0); send(0, 0, 0); send(0, 0, 0); send(0, 0, 0);
        send(0, -9, 0); send(0, 0, 0); send(0, 0, 0); send(0, 0, 0);
        // saturation
        repeat (4) send(0, 32'h4000_0000, 0);
        repeat (4) send(0, 32'hC000_0000, 0);
        drain();

        // backpressure: result held, upstream beat stalled
        a_ready = 1'b0;
        repeat (4) send(0, 40, 0);
        a_data = 1; a_bias = 0; a_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("bp_ready_low", a_oready, 0);
        end
        @(posedge clk); #1;
        a_ready = 1'b1;
        repeat (4) send(0, 1, 0);
        drain();

        // clear mid-group drops the partial sum and the beat presented with it
        send(0, 100, 0); send(0, 100, 0);
        a_clear = 1'b1; a_data = 100; a_valid = 1'b1;
        @(posedge clk); #1;
        a_clear = 1'b0; a_valid = 1'b0;
        repeat (4) send(0, 16, 0);
        drain();

        // reset mid-group
        send(0, 100, 0); send(0, 100, 0);
        rst = 1'b1;
        #1;
        check("rst_mid_valid", a_ovalid, 0);
        check("rst_mid_data", a_odata, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) send(0, 16, 0);
        check("rst_after_value", longint'($signed(a_odata)), 4);
        drain();

        // NUM_ITER=1 back-to-back
        send(1, 1, 5); send(1, 2, 5); send(1, 3, 5);
        @(negedge clk); #1;
        check("b_back_to_back_run", b_run, 3);
        drain();

        // randomized groups with random downstream backpressure
        rand_bp = 1'b1;
        for (int g = 0; g < 30; g++) begin
            bit big;
            big = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < NI_A; k++) send(0, rnd_val(big), rnd_val(big));
        end
        for (int g = 0; g < 30; g++) send(1, rnd_val($urandom_range(0, 3) == 0), rnd_val(1'b0));
        rand_bp = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/channel_accumulator.md
Name: channel_accumulator

Overview:
- Sequential stage directly downstream of the combinational pairwise adder tree. It consumes one reduced partial sum per cycle.
- Accumulates NUM_ITER consecutive sums (one per input-channel tile) on top of a per-output bias, then applies a rounding arithmetic right shift and signed saturation.
- Emits one quantised result per NUM_ITER accepted beats on a valid/ready interface.
- Sits between the adder tree and the activation/feature-map writeback logic.

Parameters:
- DATA_WIDTH, 32, width of the signed adder-tree sum and of the bias.
- ACC_WIDTH, 40, internal signed accumulator width. Must be >= DATA_WIDTH + clog2(NUM_ITER) + 1.
- OUT_WIDTH, 16, signed output width after saturation.
- NUM_ITER, 4, beats accumulated per result. Must be >= 1.
- SHIFT, 4, arithmetic right-shift amount applied to the final sum. Must be >= 0.

Ports:
- clk  in  1  single clock; all registers update on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- i_data  in  DATA_WIDTH  signed partial sum from the adder tree.
- i_valid  in  1  i_data is valid.
- o_ready  out  1  block can accept a beat this cycle.
- i_bias  in  DATA_WIDTH  signed bias; sampled only on the first beat of a group.
- i_clear  in  1  synchronous flush of the partial accumulation.
- o_data  out  OUT_WIDTH  signed quantised result.
- o_valid  out  1  o_data is valid.
- i_ready  in  1  downstream accepts o_data.

Behaviour:
- Reset (async, rst=1):
  - cnt=0, acc=0, o_valid=0, o_data=0.
  - Reset mid-group discards the partial sum; the first beat after release starts a new group.
- Handshake:
  - o_ready = !o_valid || i_ready (combinational path from i_ready).
  - Beat accepted when i_valid && o_ready && !i_clear.
  - Output transfer when o_valid && i_ready.
- Counter cnt counts 0..NUM_ITER-1, state held implicitly by cnt. On an accepted beat:
  - cnt==0: acc <= sext(i_bias) + sext(i_data).
  - Otherwise: acc <= acc + sext(i_data).
  - cnt==NUM_ITER-1: cnt <= 0 and the result is loaded.
  - Otherwise: cnt <= cnt+1.
  - NUM_ITER=1: every accepted beat is both first and last; bias is added and a result is loaded each beat.
- Result path, combinational from the final beat:
  - f = (cnt==0 ? sext(i_bias) : acc) + sext(i_data), computed in ACC_WIDTH.
  - If SHIFT>0: r = (f + 2^(SHIFT-1)) >>> SHIFT, i.e. round half toward +inf. If SHIFT=0: r = f.
  - Saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - o_data is registered with that value and o_valid<=1. Latency: o_valid rises the cycle after the last beat is accepted.
- o_valid update:
  - Cleared on a transfer unless a new result loads the same cycle; in that case it stays 1 with the new o_data.
  - o_data is held stable while o_valid && !i_ready.
- Accumulator arithmetic: two's complement, wraps modulo 2^ACC_WIDTH with no overflow flag. The parameter rule above guarantees no wrap for in-range inputs.
- i_clear:
  - Sets cnt<=0 and acc<=0; any beat presented that cycle is ignored. i_clear has priority over the beat.
  - Does not affect o_valid or o_data.
- Backpressure: when o_valid && !i_ready, o_ready=0 and no beat is accepted, including non-final beats. Upstream must hold i_data/i_valid.

Decomposition:
- Shared package: clog2 constant function, and a helper for the ACC_WIDTH legality check (elaboration-time error if violated).
- Sub-module round_saturate: combinational; parameters IN_WIDTH, OUT_WIDTH, SHIFT; input f, output saturated r. It is reused by other quantising stages.

Test Plan (defaults: NUM_ITER=4, SHIFT=4, OUT_WIDTH=16, i_ready=1 unless stated):
- Basic accumulate: bias=8; data 16,32,48,64 on consecutive cycles -> single o_valid pulse one cycle after the 4th beat, o_data=11 ((168+8)>>4).
- Rounding of negatives: bias=0; data -8,0,0,0 -> o_data=0. Then data -9,0,0,0 -> o_data=-1.
- Saturation: bias=0; data 0x40000000 x4 -> o_data=32767. Then data 0xC0000000 x4 -> o_data=-32768.
- Backpressure: hold i_ready=0 after a result and keep i_valid=1 -> o_ready=0, o_data stable, cnt frozen. Raise i_ready -> transfer, then the next group (data 1 x4, bias 0) gives o_data=0 ((4+8)>>4).
- Clear and reset mid-group:
  - 2 beats of 100, then i_clear with i_valid=1 -> that beat is dropped. Next bias 0, data 16 x4 -> o_data=4.
  - Repeat with an rst pulse instead of i_clear -> o_valid=0, o_data=0 immediately, same following result.
- Back-to-back groups with NUM_ITER=1 (SHIFT=0): bias=5; data 1,2,3 -> o_data 6,7,8 on consecutive cycles, o_valid continuously 1.
